// File: rtl/bkm_emode_iter_if.sv
// Handshake/data bundle for the BKM E-mode iteration engine.
// The master drives operands and digits; the slave (engine) returns status and the iterate.
interface bkm_emode_iter_if #(
   parameter int W      = 16,
   parameter int STEP_W = 5
);
   logic                ena;
   logic                start;
   logic signed [W-1:0] x_in;
   logic                d_valid;
   logic [1:0]          d;
   logic                ready;
   logic                busy;
   logic                d_ready;
   logic [STEP_W-1:0]   step;
   logic signed [W-1:0] x_out;
   logic                done;
   logic                ovf;
   logic                dig_err;

   modport master (
      output ena, start, x_in, d_valid, d,
      input  ready, busy, d_ready, step, x_out, done, ovf, dig_err
   );

   modport slave (
      input  ena, start, x_in, d_valid, d,
      output ready, busy, d_ready, step, x_out, done, ovf, dig_err
   );
endinterface

// File: rtl/bkm_emode_iter.sv
// BKM E-mode iteration engine: x(n+1) = x(n) + d(n)*(x(n) >>> n), one accepted digit per step.
// Optional macro BKM_EMODE_SAT_EN: saturate x_out on overflow instead of wrapping modulo 2^W.
module bkm_emode_iter #(
   parameter int W      = 16,
   parameter int N      = 16,
   parameter int STEP_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   bkm_emode_iter_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t              state_q, state_d;
   logic signed [W-1:0] x_q, x_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic                done_q, done_d;
   logic                ovf_q, ovf_d;
   logic                dig_err_q, dig_err_d;
   logic                ready_q, ready_d;
   logic                busy_q, busy_d;

   logic signed [W-1:0] shift_t;
   logic signed [W:0]   r_full;
   logic signed [W-1:0] r_res;
   logic                r_ovf;
   logic                last_dig;

   function automatic logic signed [W:0] sext(input logic signed [W-1:0] a);
      return {a[W-1], a};
   endfunction

   // Same (+/-a) + (+/-b) primitive as the upstream add_subb stage, one guard bit wide.
   function automatic logic signed [W:0] add_sub(input logic signed [W:0] a,
                                                  input logic signed [W:0] b,
                                                  input logic          neg_a,
                                                  input logic          neg_b);
      logic signed [W:0] oa;
      logic signed [W:0] ob;
      oa = neg_a ? -a : a;
      ob = neg_b ? -b : b;
      return oa + ob;
   endfunction

   function automatic logic out_of_range(input logic signed [W:0] v);
      return v[W] ^ v[W-1];
   endfunction

   function automatic logic signed [W-1:0] resolve(input logic signed [W:0] v);
      logic signed [W-1:0] res;
      res = v[W-1:0];
`ifdef BKM_EMODE_SAT_EN
      if (out_of_range(v)) begin
         res = v[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
`endif
      return res;
   endfunction

   // Arithmetic shift floors toward -inf, so small negative iterates keep contributing -1.
   always_comb begin
      shift_t = x_q >>> step_q;
      case (bus.d)
         2'b01:   r_full = add_sub(sext(x_q), sext(shift_t), 1'b0, 1'b0);
         2'b11:   r_full = add_sub(sext(x_q), sext(shift_t), 1'b0, 1'b1);
         default: r_full = sext(x_q);
      endcase
      r_ovf = out_of_range(r_full);
      r_res = resolve(r_full);
   end

   assign last_dig = (step_q == STEP_W'(N - 1));

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      step_d    = step_q;
      done_d    = done_q;
      ovf_d     = ovf_q;
      dig_err_d = dig_err_q;
      if (bus.ena) begin
         case (state_q)
            S_IDLE: begin
               // A digit presented alongside start is deliberately not consumed.
               if (bus.start) begin
                  x_d       = bus.x_in;
                  step_d    = '0;
                  ovf_d     = 1'b0;
                  dig_err_d = 1'b0;
                  state_d   = S_RUN;
               end
            end
            S_RUN: begin
               if (bus.d_valid) begin
                  x_d    = r_res;
                  step_d = step_q + STEP_W'(1);
                  if (r_ovf) begin
                     ovf_d = 1'b1;
                  end
                  if (bus.d == 2'b10) begin
                     dig_err_d = 1'b1;
                  end
                  if (last_dig) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
               done_d  = 1'b0;
            end
            default: begin
               state_d = S_IDLE;
               done_d  = 1'b0;
            end
         endcase
      end
      ready_d = (state_d == S_IDLE);
      busy_d  = (state_d == S_RUN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         x_q       <= '0;
         step_q    <= '0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
         dig_err_q <= 1'b0;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         step_q    <= step_d;
         done_q    <= done_d;
         ovf_q     <= ovf_d;
         dig_err_q <= dig_err_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.ready   = ready_q;
   assign bus.busy    = busy_q;
   assign bus.d_ready = busy_q;
   assign bus.step    = step_q;
   assign bus.x_out   = x_q;
   assign bus.done    = done_q;
   assign bus.ovf     = ovf_q;
   assign bus.dig_err = dig_err_q;

endmodule

// File: tb/tb_bkm_emode_iter.sv
// Bench for bkm_emode_iter at W=8, N=4: scenario tasks with a queue of expected results.
module tb_bkm_emode_iter;
   localparam int W      = 8;
   localparam int N      = 4;
   localparam int STEP_W = 5;
   localparam int BUDGET = 64;
   localparam int MAXV   = (1 << (W - 1)) - 1;
   localparam int MINV   = -(1 << (W - 1));

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bkm_emode_iter_if #(.W(W), .STEP_W(STEP_W)) bus ();
   bkm_emode_iter #(.W(W), .N(N), .STEP_W(STEP_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic signed [W-1:0] x;
      bit                  ovf;
      bit                  derr;
      int                  lat;
   } res_t;

   res_t       exp_q[$];
   int         vec_cnt = 0;
   int         err_cnt = 0;

   // Per-cycle stimulus table played after start acceptance.
   bit         c_ena[32];
   bit         c_dv[32];
   bit         c_st[32];
   logic [1:0] c_d[32];
   int         ncyc;

   res_t       got;
   bit         got_timeout;
   bit         got_pulse_ok;
   int         got_freeze_bad;

   function automatic res_t mk(input int x, input bit ovf, input bit derr, input int lat);
      res_t r;
      r.x = x[W-1:0]; r.ovf = ovf; r.derr = derr; r.lat = lat;
      return r;
   endfunction

   task automatic add_cyc(input bit en, input bit dv, input logic [1:0] dd, input bit st = 1'b0);
      c_ena[ncyc] = en; c_dv[ncyc] = dv; c_d[ncyc] = dd; c_st[ncyc] = st;
      ncyc++;
   endtask

   // Integer reference: x + d*floor(x / 2^n), range-checked, then wrapped or clamped.
   function automatic res_t model(input int x0);
      res_t r;
      int x, t, v, n;
      x = x0; n = 0;
      r.ovf = 1'b0; r.derr = 1'b0; r.lat = 0;
      for (int i = 0; i < ncyc && n < N; i++) begin
         if (c_ena[i] && c_dv[i]) begin
            t = x >>> n;
            v = (c_d[i] == 2'b01) ? x + t : (c_d[i] == 2'b11) ? x - t : x;
            if (c_d[i] == 2'b10) r.derr = 1'b1;
            if (v > MAXV || v < MINV) begin
               r.ovf = 1'b1;
`ifdef BKM_EMODE_SAT_EN
               v = (v > MAXV) ? MAXV : MINV;
`else
               v = ((v - MINV) & ((1 << W) - 1)) + MINV;
`endif
            end
            x = v;
            n++;
            if (n == N) r.lat = i + 2;
         end
      end
      r.x = x[W-1:0];
      return r;
   endfunction

   task automatic run_op(input logic signed [W-1:0] x0, input bit dv_on_start);
      logic signed [W-1:0] sx;
      logic [STEP_W-1:0]   sstep;
      logic                sb, so, sd;
      int                  idx;
      bit                  seen;
      idx = 0; seen = 1'b0;
      got_timeout = 1'b0; got_freeze_bad = 0; got_pulse_ok = 1'b0;
      @(negedge clk);
      bus.ena = 1'b1; bus.start = 1'b1; bus.x_in = x0; bus.d_valid = dv_on_start; bus.d = 2'b01;
      @(negedge clk);
      bus.start = 1'b0; bus.d_valid = 1'b0; bus.x_in = ~x0;
      got.lat = 1;
      while (!seen && got.lat < BUDGET) begin
         sx = bus.x_out; sstep = bus.step; sb = bus.busy; so = bus.ovf; sd = bus.dig_err;
         if (idx < ncyc) begin
            bus.ena = c_ena[idx]; bus.d_valid = c_dv[idx]; bus.d = c_d[idx]; bus.start = c_st[idx];
         end else begin
            bus.ena = 1'b1; bus.d_valid = 1'b0; bus.start = 1'b0;
         end
         @(negedge clk);
         got.lat++;
         if (idx < ncyc && !(c_ena[idx] && c_dv[idx]) &&
             {sx, sstep, sb, so, sd} !== {bus.x_out, bus.step, bus.busy, bus.ovf, bus.dig_err})
            got_freeze_bad++;
         idx++;
         seen = (bus.done === 1'b1);
      end
      got.x = bus.x_out; got.ovf = bus.ovf; got.derr = bus.dig_err;
      got_timeout = !seen;
      bus.ena = 1'b1; bus.d_valid = 1'b0; bus.start = 1'b0;
      @(negedge clk);
      got_pulse_ok = (bus.done === 1'b0 && bus.ready === 1'b1 && bus.x_out === got.x);
   endtask

   task automatic test_reset();
      @(negedge clk);
      vec_cnt++;
      if ({bus.ready, bus.busy, bus.d_ready, bus.done, bus.ovf, bus.dig_err} !== 6'b100000) begin
         err_cnt++;
         $display("FAIL reset_flags: got rdy/busy/drdy/done/ovf/derr=%b required 100000",
                  {bus.ready, bus.busy, bus.d_ready, bus.done, bus.ovf, bus.dig_err});
      end
      vec_cnt++;
      if (bus.x_out !== '0 || bus.step !== '0) begin
         err_cnt++;
         $display("FAIL reset_data: got x_out=%0d step=%0d required 0/0", bus.x_out, bus.step);
      end
      rst = 1'b0;
   endtask

   task automatic test_nominal();
      res_t e;
      ncyc = 0;
      add_cyc(1, 1, 2'b01); add_cyc(1, 1, 2'b01); add_cyc(1, 1, 2'b00); add_cyc(1, 1, 2'b00);
      exp_q.push_back(mk(96, 1'b0, 1'b0, 5));
      run_op(8'sd32, 1'b0);
      e = exp_q.pop_front();
      vec_cnt++; if (got_timeout) begin err_cnt++; $display("FAIL nominal_done: got no done required done within %0d cycles", BUDGET); end
      vec_cnt++; if (got.x !== e.x) begin err_cnt++; $display("FAIL nominal_x: got %0d required %0d", got.x, e.x); end
      vec_cnt++; if ({got.ovf, got.derr} !== {e.ovf, e.derr}) begin err_cnt++; $display("FAIL nominal_flags: got ovf/derr=%b%b required %b%b", got.ovf, got.derr, e.ovf, e.derr); end
      vec_cnt++; if (got.lat !== e.lat) begin err_cnt++; $display("FAIL nominal_latency: got %0d required %0d", got.lat, e.lat); end
      vec_cnt++; if (!got_pulse_ok) begin err_cnt++; $display("FAIL nominal_done_pulse: got done held or not idle required single pulse then idle"); end
   endtask

   task automatic test_negative();
      res_t e;
      ncyc = 0;
      add_cyc(1, 1, 2'b00); add_cyc(1, 1, 2'b11); add_cyc(1, 1, 2'b00); add_cyc(1, 1, 2'b01);
      exp_q.push_back(mk(-36, 1'b0, 1'b0, 5));
      run_op(-8'sd64, 1'b1);
      e = exp_q.pop_front();
      vec_cnt++; if (got_timeout) begin err_cnt++; $display("FAIL negative_done: got no done required done within %0d cycles", BUDGET); end
      vec_cnt++; if (got.x !== e.x) begin err_cnt++; $display("FAIL negative_x: got %0d required %0d", got.x, e.x); end
      vec_cnt++; if (got.lat !== e.lat) begin err_cnt++; $display("FAIL negative_latency: got %0d required %0d", got.lat, e.lat); end
   endtask

   task automatic test_overflow();
      res_t e;
      ncyc = 0;
      add_cyc(1, 1, 2'b01); add_cyc(1, 1, 2'b00); add_cyc(1, 1, 2'b00); add_cyc(1, 1, 2'b00);
`ifdef BKM_EMODE_SAT_EN
      exp_q.push_back(mk(127, 1'b1, 1'b0, 5));
`else
      exp_q.push_back(mk(-56, 1'b1, 1'b0, 5));
`endif
      run_op(8'sd100, 1'b0);
      e = exp_q.pop_front();
      vec_cnt++; if (got_timeout) begin err_cnt++; $display("FAIL overflow_done: got no done required done within %0d cycles", BUDGET); end
      vec_cnt++; if (got.x !== e.x) begin err_cnt++; $display("FAIL overflow_x: got %0d required %0d", got.x, e.x); end
      vec_cnt++; if (got.ovf !== e.ovf) begin err_cnt++; $display("FAIL overflow_ovf: got %0b required %0b", got.ovf, e.ovf); end
   endtask

   task automatic test_stall_illegal();
      res_t e;
      ncyc = 0;
      add_cyc(1, 1, 2'b01);
      add_cyc(1, 0, 2'b01); add_cyc(1, 0, 2'b11); add_cyc(1, 0, 2'b01);
      add_cyc(1, 1, 2'b10); add_cyc(1, 1, 2'b00); add_cyc(1, 1, 2'b00);
      exp_q.push_back(mk(32, 1'b0, 1'b1, 8));
      run_op(8'sd16, 1'b0);
      e = exp_q.pop_front();
      vec_cnt++; if (got_timeout) begin err_cnt++; $display("FAIL stall_done: got no done required done within %0d cycles", BUDGET); end
      vec_cnt++; if (got.x !== e.x) begin err_cnt++; $display("FAIL stall_x: got %0d required %0d", got.x, e.x); end
      vec_cnt++; if ({got.ovf, got.derr} !== {e.ovf, e.derr}) begin err_cnt++; $display("FAIL stall_flags: got ovf/derr=%b%b required %b%b", got.ovf, got.derr, e.ovf, e.derr); end
      vec_cnt++; if (got.lat !== e.lat) begin err_cnt++; $display("FAIL stall_latency: got %0d required %0d", got.lat, e.lat); end
      vec_cnt++; if (got_freeze_bad !== 0) begin err_cnt++; $display("FAIL stall_hold: got %0d changed stall cycles required 0", got_freeze_bad); end
   endtask

   task automatic test_ignored_start_ena();
      res_t e;
      ncyc = 0;
      add_cyc(1, 1, 2'b01);
      add_cyc(1, 1, 2'b11, 1'b1);
      add_cyc(0, 1, 2'b01); add_cyc(0, 1, 2'b01);
      add_cyc(1, 1, 2'b01); add_cyc(1, 1, 2'b00);
      exp_q.push_back(mk(25, 1'b0, 1'b0, 7));
      run_op(8'sd20, 1'b0);
      e = exp_q.pop_front();
      vec_cnt++; if (got_timeout) begin err_cnt++; $display("FAIL ena_done: got no done required done within %0d cycles", BUDGET); end
      vec_cnt++; if (got.x !== e.x) begin err_cnt++; $display("FAIL ena_start_x: got %0d required %0d", got.x, e.x); end
      vec_cnt++; if (got.lat !== e.lat) begin err_cnt++; $display("FAIL ena_latency: got %0d required %0d", got.lat, e.lat); end
      vec_cnt++; if (got_freeze_bad !== 0) begin err_cnt++; $display("FAIL ena_freeze: got %0d changed frozen cycles required 0", got_freeze_bad); end
   endtask

   task automatic test_reset_mid_run();
      res_t e;
      bit   saw_done;
      bit   left_idle;
      @(negedge clk);
      bus.ena = 1'b1; bus.start = 1'b1; bus.x_in = 8'sd32; bus.d_valid = 1'b0;
      @(negedge clk);
      bus.start = 1'b0; bus.d_valid = 1'b1; bus.d = 2'b01;
      @(negedge clk);
      @(negedge clk);
      bus.d_valid = 1'b0;
      vec_cnt++;
      if (bus.x_out !== 8'sd96 || bus.step !== 5'd2) begin
         err_cnt++;
         $display("FAIL midrun_progress: got x_out=%0d step=%0d required 96/2", bus.x_out, bus.step);
      end
      rst = 1'b1;
      #1;
      vec_cnt++;
      if ({bus.ready, bus.busy, bus.done} !== 3'b100 || bus.x_out !== '0 || bus.step !== '0) begin
         err_cnt++;
         $display("FAIL midrun_abort: got rdy/busy/done=%b x_out=%0d step=%0d required 100/0/0",
                  {bus.ready, bus.busy, bus.done}, bus.x_out, bus.step);
      end
      @(negedge clk);
      rst = 1'b0;
      saw_done = 1'b0; left_idle = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (bus.done !== 1'b0) saw_done = 1'b1;
         if (bus.ready !== 1'b1) left_idle = 1'b1;
      end
      vec_cnt++;
      if (saw_done || left_idle) begin
         err_cnt++;
         $display("FAIL midrun_quiet: got done_seen=%0b left_idle=%0b required 0/0", saw_done, left_idle);
      end
      ncyc = 0;
      add_cyc(1, 1, 2'b01); add_cyc(1, 1, 2'b11); add_cyc(1, 1, 2'b01); add_cyc(1, 1, 2'b01);
      exp_q.push_back(model(-5));
      run_op(-8'sd5, 1'b0);
      e = exp_q.pop_front();
      vec_cnt++;
      if (got_timeout || got.x !== e.x || got.lat !== e.lat) begin
         err_cnt++;
         $display("FAIL midrun_restart: got x=%0d lat=%0d timeout=%0b required x=%0d lat=%0d",
                  got.x, got.lat, got_timeout, e.x, e.lat);
      end
   endtask

   task automatic test_back_to_back();
      res_t                e;
      logic signed [W-1:0] x0;
      int                  acc;
      int                  k;
      for (int op = 0; op < 6; op++) begin
         acc = 0; ncyc = 0;
         while (acc < N) begin
            k = int'($urandom_range(0, 5));
            if (k == 0 && ncyc < 20) add_cyc(1'b0, 1'b1, 2'b01);
            else if (k == 1 && ncyc < 20) add_cyc(1'b1, 1'b0, 2'b11);
            else begin add_cyc(1'b1, 1'b1, 2'($urandom_range(0, 3))); acc++; end
         end
         x0 = W'($urandom_range(0, (1 << W) - 1));
         if (op == 0) x0 = 8'sh80;
         if (op == 1) x0 = 8'sh7f;
         exp_q.push_back(model(int'(x0)));
         run_op(x0, op[0]);
         e = exp_q.pop_front();
         vec_cnt++;
         if (got_timeout || got.x !== e.x || got.ovf !== e.ovf || got.derr !== e.derr || got.lat !== e.lat) begin
            err_cnt++;
            $display("FAIL b2b_op%0d: got x=%0d ovf=%0b derr=%0b lat=%0d timeout=%0b required x=%0d ovf=%0b derr=%0b lat=%0d",
                     op, got.x, got.ovf, got.derr, got.lat, got_timeout, e.x, e.ovf, e.derr, e.lat);
         end
         vec_cnt++;
         if (got_freeze_bad !== 0 || !got_pulse_ok) begin
            err_cnt++;
            $display("FAIL b2b_hold%0d: got %0d changed stall cycles pulse_ok=%0b required 0/1", op, got_freeze_bad, got_pulse_ok);
         end
      end
   endtask

   initial begin
      bus.ena = 1'b1; bus.start = 1'b0; bus.x_in = '0; bus.d_valid = 1'b0; bus.d = 2'b00;
      test_reset();
      test_nominal();
      test_negative();
      test_overflow();
      test_stall_illegal();
      test_ignored_start_ena();
      test_reset_mid_run();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running required completion before 200000");
      $fatal(1, "watchdog expired");
   end
endmodule
